// File: rtl/hm_rd_sched.sv
// Purpose : splits a host read into 4KB-safe Memory Read chunks and sequences them to the TX engine.
// Latency : first tx_req one cycle after start; next chunk issued the cycle after its completion pulse.
// Backpres: tx_req/tx_addr/tx_len are held stable until tx_ack; start is ignored while busy.
//
// Ports:
//   trn_clk, sys_rst (sync, active-high), trn_lnk_up_n (active-low link up)
//   start/addr/total_dw : command in;  busy/done/error : status out
//   tx_req/tx_ack/tx_addr/tx_len : request handshake to the TX engine
//   rx_memory_read : last completion of the outstanding chunk has arrived
//   stat_chunks/stat_state : completed-chunk counter and raw state
// Build option: define HM_RD_SCHED_TIMEOUT_EN to add the WAIT timeout and retry logic.
// MAX_RD_DW must be 1..1023 so a chunk length always fits the 10-bit tx_len.
module hm_rd_sched #(
  parameter int unsigned MAX_RD_DW      = 128,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'hffff,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic        trn_clk,
  input  logic        sys_rst,
  input  logic        trn_lnk_up_n,
  input  logic        start,
  input  logic [63:0] addr,
  input  logic [15:0] total_dw,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        tx_req,
  input  logic        tx_ack,
  output logic [63:0] tx_addr,
  output logic [9:0]  tx_len,
  input  logic        rx_memory_read,
  output logic [15:0] stat_chunks,
  output logic [1:0]  stat_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_BAD   = 2'd3
  } state_e;

  localparam logic [15:0] MAX_DW16 = 16'(MAX_RD_DW);

  state_e      state_q, state_d;
  logic [63:0] cur_addr_q, cur_addr_d;
  logic [15:0] rem_dw_q, rem_dw_d;
  logic        tx_req_q, tx_req_d;
  logic [63:0] tx_addr_q, tx_addr_d;
  logic [9:0]  tx_len_q, tx_len_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [15:0] stat_chunks_q, stat_chunks_d;
  logic [63:0] nxt_addr;
  logic [15:0] nxt_rem;

`ifdef HM_RD_SCHED_TIMEOUT_EN
  localparam logic [7:0] MAX_RETRY8 = 8'(MAX_RETRY);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic        unused_bits;
  assign unused_bits = ^addr[1:0];
`else
  logic        unused_bits;
  assign unused_bits = ^{addr[1:0], TIMEOUT_CYCLES, 32'(MAX_RETRY)};
`endif

  // Largest chunk that fits: remaining work, max payload, and bytes left
  // before the next 4KB page (1..4096 bytes, hence the 13-bit difference).
  function automatic logic [9:0] chunk_len(input logic [11:0] a12, input logic [15:0] rem);
    logic [12:0] to_4k;
    logic [15:0] len;
    to_4k = 13'd4096 - {1'b0, a12};
    len   = rem;
    if (len > MAX_DW16) len = MAX_DW16;
    if ({5'd0, to_4k[12:2]} < len) len = {5'd0, to_4k[12:2]};
    return len[9:0];
  endfunction

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    rem_dw_d      = rem_dw_q;
    tx_addr_d     = tx_addr_q;
    tx_len_d      = tx_len_q;
    stat_chunks_d = stat_chunks_q;
    done_d        = 1'b0;
    error_d       = 1'b0;
    nxt_addr      = cur_addr_q + {52'd0, tx_len_q, 2'b00};
    nxt_rem       = rem_dw_q - {6'd0, tx_len_q};
`ifdef HM_RD_SCHED_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    retry_d       = retry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // A dead link fails the command even when it asks for zero dwords.
          if (trn_lnk_up_n) begin
            error_d = 1'b1;
          end else if (total_dw == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d    = ST_ISSUE;
            cur_addr_d = {addr[63:2], 2'b00};
            rem_dw_d   = total_dw;
            tx_addr_d  = {addr[63:2], 2'b00};
            tx_len_d   = chunk_len({addr[11:2], 2'b00}, total_dw);
`ifdef HM_RD_SCHED_TIMEOUT_EN
            retry_d    = 8'd0;
`endif
          end
        end
      end
      ST_ISSUE: begin
        if (trn_lnk_up_n) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else if (tx_ack) begin
          state_d = ST_WAIT;
`ifdef HM_RD_SCHED_TIMEOUT_EN
          tmo_cnt_d = 16'd0;
`endif
        end
      end
      ST_WAIT: begin
        if (trn_lnk_up_n) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else if (rx_memory_read) begin
          // Completion wins over a coincident timeout.
          cur_addr_d    = nxt_addr;
          rem_dw_d      = nxt_rem;
          stat_chunks_d = stat_chunks_q + 16'd1;
`ifdef HM_RD_SCHED_TIMEOUT_EN
          retry_d       = 8'd0;
`endif
          if (nxt_rem == 16'd0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_ISSUE;
            tx_addr_d = nxt_addr;
            tx_len_d  = chunk_len(nxt_addr[11:0], nxt_rem);
          end
        end
`ifdef HM_RD_SCHED_TIMEOUT_EN
        else if (tmo_cnt_q == TIMEOUT_CYCLES) begin
          // Reissue keeps tx_addr/tx_len untouched.
          if (retry_q < MAX_RETRY8) begin
            retry_d = retry_q + 8'd1;
            state_d = ST_ISSUE;
          end else begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    tx_req_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge trn_clk) begin
    if (sys_rst) begin
      state_q       <= ST_IDLE;
      cur_addr_q    <= 64'd0;
      rem_dw_q      <= 16'd0;
      tx_req_q      <= 1'b0;
      tx_addr_q     <= 64'd0;
      tx_len_q      <= 10'd0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      stat_chunks_q <= 16'd0;
`ifdef HM_RD_SCHED_TIMEOUT_EN
      tmo_cnt_q     <= 16'd0;
      retry_q       <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      rem_dw_q      <= rem_dw_d;
      tx_req_q      <= tx_req_d;
      tx_addr_q     <= tx_addr_d;
      tx_len_q      <= tx_len_d;
      done_q        <= done_d;
      error_q       <= error_d;
      stat_chunks_q <= stat_chunks_d;
`ifdef HM_RD_SCHED_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      retry_q       <= retry_d;
`endif
    end
  end

  assign busy        = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign done        = done_q;
  assign error       = error_q;
  assign tx_req      = tx_req_q;
  assign tx_addr     = tx_addr_q;
  assign tx_len      = tx_len_q;
  assign stat_chunks = stat_chunks_q;
  assign stat_state  = state_q;

endmodule

// File: tb/tb_hm_rd_sched.sv
// Bench for hm_rd_sched: command vectors, hand-written corner sequences and
// randomized transfers checked against a chunk-list reference model.
module tb_hm_rd_sched;
  logic        trn_clk = 1'b0;
  logic        sys_rst, trn_lnk_up_n, start, tx_ack, rx_memory_read;
  logic [63:0] addr;
  logic [15:0] total_dw;
  logic        busy, done, error, tx_req;
  logic [63:0] tx_addr;
  logic [9:0]  tx_len;
  logic [15:0] stat_chunks;
  logic [1:0]  stat_state;

  int tests = 0;
  int fails = 0;
  int exp_chunks = 0;
  logic [63:0] exp_a[$];
  int          exp_l[$];
  logic [63:0] obs_a[$];
  int          obs_l[$];

  always #5 trn_clk = ~trn_clk;

  hm_rd_sched #(.MAX_RD_DW(128), .TIMEOUT_CYCLES(16'd100), .MAX_RETRY(3)) dut (
    .trn_clk(trn_clk), .sys_rst(sys_rst), .trn_lnk_up_n(trn_lnk_up_n),
    .start(start), .addr(addr), .total_dw(total_dw),
    .busy(busy), .done(done), .error(error),
    .tx_req(tx_req), .tx_ack(tx_ack), .tx_addr(tx_addr), .tx_len(tx_len),
    .rx_memory_read(rx_memory_read), .stat_chunks(stat_chunks), .stat_state(stat_state)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge trn_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
    exp_chunks = 0;
  endtask

  // Invariants watched every cycle.
  always @(negedge trn_clk) begin
    tests++;
    if (done && error) begin
      fails++;
      $display("FAIL done_error_overlap: done=%0b error=%0b, expected never both", done, error);
    end
    if (busy !== (stat_state == 2'd1 || stat_state == 2'd2)) begin
      fails++;
      $display("FAIL busy_vs_state: busy=%0b stat_state=%0d", busy, stat_state);
    end
  end

  // Reference: greedy split into chunks bounded by remaining, 128 and the 4KB page.
  function automatic void build_model(input logic [63:0] a, input int n);
    logic [63:0] cur;
    int rem, room, len;
    exp_a.delete();
    exp_l.delete();
    cur = a & ~64'h3;
    rem = n;
    while (rem > 0) begin
      room = (4096 - int'(cur % 64'd4096)) / 4;
      len = rem;
      if (len > 128) len = 128;
      if (len > room) len = room;
      exp_a.push_back(cur);
      exp_l.push_back(len);
      cur = cur + 64'(len * 4);
      rem = rem - len;
    end
  endfunction

  task automatic do_xfer(input logic [63:0] a, input int n, input int ack_dly,
                         input int rx_dly, input bit noise);
    int  nch;
    bit  ok;
    build_model(a, n);
    nch = exp_a.size();
    obs_a.delete();
    obs_l.delete();
    start = 1'b1; addr = a; total_dw = 16'(n);
    tick();
    start = 1'b0;
    for (int c = 0; c < nch; c++) begin
      ok = 1'b0;
      for (int w = 0; w < 20 && !ok; w++) begin
        if (tx_req) ok = 1'b1; else tick();
      end
      chk("req_seen", 64'(ok), 64'd1);
      if (!ok) return;
      obs_a.push_back(tx_addr);
      obs_l.push_back(int'(tx_len));
      chk("chunk_addr", tx_addr, exp_a[c]);
      chk("chunk_len", 64'(tx_len), 64'(exp_l[c]));
      for (int d = 0; d < ack_dly; d++) begin
        rx_memory_read = noise & 1'($urandom_range(0, 1));
        tick();
        rx_memory_read = 1'b0;
        chk("req_hold", 64'(tx_req), 64'd1);
        chk("addr_hold", tx_addr, exp_a[c]);
        chk("len_hold", 64'(tx_len), 64'(exp_l[c]));
      end
      tx_ack = 1'b1;
      tick();
      tx_ack = 1'b0;
      chk("req_drop", 64'(tx_req), 64'd0);
      for (int d = 0; d < rx_dly; d++) begin
        if (noise) begin
          start = 1'($urandom_range(0, 1));
          addr = {$urandom, $urandom};
          total_dw = 16'($urandom);
        end
        tick();
        start = 1'b0;
      end
      rx_memory_read = 1'b1;
      tick();
      rx_memory_read = 1'b0;
      exp_chunks++;
      if (c == nch - 1) chk("last_done", 64'({done, busy, error}), 64'b100);
      else              chk("next_issue", 64'({done, tx_req, error}), 64'b010);
    end
    tick();
    chk("done_pulse", 64'({done, busy}), 64'd0);
    chk("stat_chunks", 64'(stat_chunks), 64'(16'(exp_chunks)));
  endtask

  typedef struct {
    string       name;
    logic        st;
    logic [63:0] a;
    logic [15:0] n;
    logic        lnk_n;
    logic        e_done, e_err, e_busy, e_req;
    logic [63:0] e_addr;
    logic [9:0]  e_len;
  } vec_t;

  vec_t vecs[10];
  int   reqs;
  bit   err_seen;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b0; trn_lnk_up_n = 1'b0; start = 1'b0; tx_ack = 1'b0;
    rx_memory_read = 1'b0; addr = 64'd0; total_dw = 16'd0;
    vecs[0] = '{"zero_len",    1'b1, 64'h1000,                16'd0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,     10'd0};
    vecs[1] = '{"link_down",   1'b1, 64'h1000,                16'd5,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,     10'd0};
    vecs[2] = '{"no_start",    1'b0, 64'h1000,                16'd5,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,     10'd0};
    vecs[3] = '{"max_chunk",   1'b1, 64'h1000,                16'd300,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h1000,  10'd128};
    vecs[4] = '{"page_split",  1'b1, 64'h1FF0,                16'd10,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h1FF0,  10'd4};
    vecs[5] = '{"low_bits",    1'b1, 64'h1FF3,                16'd10,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h1FF0,  10'd4};
    vecs[6] = '{"one_dw_room", 1'b1, 64'h0FFC,                16'd100,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0FFC,  10'd1};
    vecs[7] = '{"short",       1'b1, 64'h0,                   16'd50,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0,     10'd50};
    vecs[8] = '{"high_addr",   1'b1, 64'hFFFF_FFFF_0000_0800, 16'd2000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_0000_0800, 10'd128};
    vecs[9] = '{"room_64",     1'b1, 64'h0F00,                16'd200,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0F00,  10'd64};

    // Reset state.
    do_reset();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_flags", 64'({done, error, tx_req}), 64'd0);
    chk("rst_tx_addr", tx_addr, 64'd0);
    chk("rst_tx_len", 64'(tx_len), 64'd0);
    chk("rst_stat", 64'({stat_chunks, stat_state}), 64'd0);

    // Single-cycle command responses from IDLE.
    for (int i = 0; i < 10; i++) begin
      do_reset();
      start = vecs[i].st; addr = vecs[i].a; total_dw = vecs[i].n; trn_lnk_up_n = vecs[i].lnk_n;
      tick();
      start = 1'b0; trn_lnk_up_n = 1'b0;
      chk($sformatf("%s.done", vecs[i].name), 64'(done), 64'(vecs[i].e_done));
      chk($sformatf("%s.error", vecs[i].name), 64'(error), 64'(vecs[i].e_err));
      chk($sformatf("%s.busy", vecs[i].name), 64'(busy), 64'(vecs[i].e_busy));
      chk($sformatf("%s.tx_req", vecs[i].name), 64'(tx_req), 64'(vecs[i].e_req));
      chk($sformatf("%s.tx_addr", vecs[i].name), tx_addr, vecs[i].e_addr);
      chk($sformatf("%s.tx_len", vecs[i].name), 64'(tx_len), 64'(vecs[i].e_len));
      tick();
      chk($sformatf("%s.pulse_end", vecs[i].name), 64'({done, error}), 64'd0);
    end

    // Plain multi-chunk read.
    do_reset();
    do_xfer(64'h1000, 300, 1, 20, 1'b0);
    chk("mc_nchunks", 64'(obs_a.size()), 64'd3);
    chk("mc_a0", (obs_a.size() > 0) ? obs_a[0] : '1, 64'h1000);
    chk("mc_a1", (obs_a.size() > 1) ? obs_a[1] : '1, 64'h1200);
    chk("mc_a2", (obs_a.size() > 2) ? obs_a[2] : '1, 64'h1400);
    chk("mc_l2", (obs_l.size() > 2) ? 64'(obs_l[2]) : '1, 64'd44);
    chk("mc_stat", 64'(stat_chunks), 64'd3);

    // 4KB boundary split.
    do_xfer(64'h1FF0, 10, 1, 3, 1'b0);
    chk("pg_nchunks", 64'(obs_a.size()), 64'd2);
    chk("pg_a1", (obs_a.size() > 1) ? obs_a[1] : '1, 64'h2000);
    chk("pg_l1", (obs_l.size() > 1) ? 64'(obs_l[1]) : '1, 64'd6);

    // Link loss while waiting on chunk 2; a late completion is ignored.
    do_reset();
    start = 1'b1; addr = 64'h1000; total_dw = 16'd300;
    tick();
    start = 1'b0;
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;
    tick(); tick();
    rx_memory_read = 1'b1; tick(); rx_memory_read = 1'b0;
    chk("ll_chunk2_addr", tx_addr, 64'h1200);
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;
    tick();
    chk("ll_in_wait", 64'(stat_state), 64'd2);
    trn_lnk_up_n = 1'b1;
    tick();
    trn_lnk_up_n = 1'b0;
    chk("ll_error", 64'({error, done, busy, tx_req}), 64'b1000);
    tick();
    chk("ll_error_pulse", 64'(error), 64'd0);
    rx_memory_read = 1'b1; tick(); rx_memory_read = 1'b0;
    chk("ll_rx_ignored", 64'({stat_chunks, done, busy}), 64'({16'd1, 2'b00}));

    // Link loss beats tx_ack in ISSUE and rx_memory_read in WAIT.
    start = 1'b1; addr = 64'h3000; total_dw = 16'd8;
    tick();
    start = 1'b0;
    trn_lnk_up_n = 1'b1; tx_ack = 1'b1;
    tick();
    trn_lnk_up_n = 1'b0; tx_ack = 1'b0;
    chk("pri_issue", 64'({error, tx_req, stat_state}), 64'({2'b10, 2'd0}));
    start = 1'b1;
    tick();
    start = 1'b0;
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;
    trn_lnk_up_n = 1'b1; rx_memory_read = 1'b1;
    tick();
    trn_lnk_up_n = 1'b0; rx_memory_read = 1'b0;
    chk("pri_wait", 64'({error, done, stat_state}), 64'({2'b10, 2'd0}));
    chk("pri_wait_stat", 64'(stat_chunks), 64'd1);

    // Reset while a request is pending, then a fresh start.
    start = 1'b1; addr = 64'h5000; total_dw = 16'd64;
    tick();
    start = 1'b0;
    chk("rm_req_up", 64'(tx_req), 64'd1);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    exp_chunks = 0;
    chk("rm_flags", 64'({busy, done, error, tx_req}), 64'd0);
    chk("rm_tx", {tx_addr[53:0], tx_len}, 64'd0);
    chk("rm_stat", 64'({stat_chunks, stat_state}), 64'd0);
    tick(); tick(); tick();
    chk("rm_no_auto_req", 64'(tx_req), 64'd0);
    do_xfer(64'h7004, 20, 0, 2, 1'b0);

    // Timeout behaviour.
    do_reset();
    start = 1'b1; addr = 64'h8000; total_dw = 16'd16;
    tick();
    start = 1'b0;
`ifdef HM_RD_SCHED_TIMEOUT_EN
    reqs = 0;
    err_seen = 1'b0;
    for (int c = 0; c < 2000 && !err_seen; c++) begin
      if (error) err_seen = 1'b1;
      else if (tx_req) begin
        reqs++;
        chk("to_same_addr", tx_addr, 64'h8000);
        chk("to_same_len", 64'(tx_len), 64'd16);
        tick();
        tx_ack = 1'b1; tick(); tx_ack = 1'b0;
      end else tick();
    end
    chk("to_reqs", 64'(reqs), 64'd4);
    chk("to_error", 64'({err_seen, busy}), 64'b10);
    // Completion landing on the expiry cycle counts as success.
    start = 1'b1;
    tick();
    start = 1'b0;
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;
    for (int k = 0; k < 100; k++) tick();
    rx_memory_read = 1'b1; tick(); rx_memory_read = 1'b0;
    chk("to_tie_success", 64'({done, error, busy}), 64'b100);
`else
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;
    err_seen = 1'b0;
    reqs = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (error) err_seen = 1'b1;
      if (tx_req) reqs++;
    end
    chk("nt_no_error", 64'(err_seen), 64'd0);
    chk("nt_no_reissue", 64'(reqs), 64'd0);
    chk("nt_still_wait", 64'({busy, stat_state}), 64'({1'b1, 2'd2}));
    rx_memory_read = 1'b1; tick(); rx_memory_read = 1'b0;
    chk("nt_done", 64'({done, busy}), 64'b10);
`endif

    // Randomized transfers against the chunk-list model.
    do_reset();
    for (int t = 0; t < 30; t++) begin
      logic [63:0] ra;
      ra = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) ra[11:0] = 12'hFFF - 12'($urandom_range(0, 40));
      do_xfer(ra, int'($urandom_range(1, 600)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 6)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
